mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 24 ++
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_core.sv | 66 ++++++
 rtl/mul_div_unit.sv | 107 ++++++++++
 tb/tb_mul_div_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int MDU_WIDTH      = 64;
  localparam int MDU_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the register-file read ports, the unit and the write-port mux.
interface mul_div_unit_if #(
  parameter int WIDTH      = mul_div_unit_pkg::MDU_WIDTH,
  parameter int REG_ADDR_W = mul_div_unit_pkg::MDU_REG_ADDR_W
);
  logic                  Start;
  logic [1:0]            Op;
  logic [WIDTH-1:0]      Operand1;
  logic [WIDTH-1:0]      Operand2;
  logic [REG_ADDR_W-1:0] DestReg;
  logic                  Ready;
  logic                  Done;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [WIDTH-1:0]      WriteData;

  modport master (
    output Start, Op, Operand1, Operand2, DestReg,
    input  Ready, Done, RegWrite, WriteReg, WriteData
  );

  modport slave (
    input  Start, Op, Operand1, Operand2, DestReg,
    output Ready, Done, RegWrite, WriteReg, WriteData
  );
endinterface

// File: rtl/mul_div_core.sv
// Shared iteration datapath: shift-add multiplier and restoring divider over one register pair.
module mul_div_core import mul_div_unit_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // acc holds product-high or remainder; lo holds product-low or quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = lo_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    acc_d     = acc_q;
    lo_d      = lo_q;
    if (div_q) begin
      if (!div_diff[WIDTH+1]) begin
        acc_d = div_diff[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= '0;
      lo_q  <= is_div_i ? a_i : b_i;
      b_q   <= is_div_i ? b_i : a_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
    end
  end

  assign hi_o = acc_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mul_div_unit.sv
// Fixed-latency unsigned MUL/MULHU/DIVU/REMU unit feeding the register-file write port.
//   state | meaning
//   IDLE  | Ready=1, waiting for Start; operands captured on accept
//   RUN   | one datapath iteration per clock, WIDTH iterations total
//   DONE  | one-cycle Done/RegWrite pulse with WriteReg/WriteData valid
module mul_div_unit import mul_div_unit_pkg::*; #(
  parameter int WIDTH      = MDU_WIDTH,
  parameter int REG_ADDR_W = MDU_REG_ADDR_W
) (
  input  logic           Clock,
  input  logic           Reset_n,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q;
  op_e                   op_q;
  logic                  dz_q;
  logic [WIDTH-1:0]      op1_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      core_hi, core_lo;
  logic [WIDTH-1:0]      result;
  logic                  accept;
  logic                  last_iter;

  assign accept    = (state_q == IDLE) && bus.Start;
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  mul_div_core #(.WIDTH(WIDTH)) u_core (
    .clk_i    (Clock),
    .rst_ni   (Reset_n),
    .load_i   (accept),
    .step_i   (state_q == RUN),
    .is_div_i (op_is_div(op_e'(bus.Op))),
    .a_i      (bus.Operand1),
    .b_i      (bus.Operand2),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divide-by-zero overrides are applied only here, at result selection
  always_comb begin
    result = core_lo;
    unique case (op_q)
      OP_MUL:   result = core_lo;
      OP_MULHU: result = core_hi;
      OP_DIVU:  result = dz_q ? '1 : core_lo;
      OP_REMU:  result = dz_q ? op1_q : core_hi;
      default:  result = core_lo;
    endcase
  end

  always_comb begin
    bus.Ready     = (state_q == IDLE);
    bus.Done      = (state_q == DONE);
    bus.RegWrite  = (state_q == DONE);
    bus.WriteReg  = (state_q == DONE) ? dest_q : wreg_q;
    bus.WriteData = (state_q == DONE) ? result : wdata_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      count_q <= '0;
      op_q    <= OP_MUL;
      dz_q    <= 1'b0;
      op1_q   <= '0;
      dest_q  <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        count_q <= '0;
        op_q    <= op_e'(bus.Op);
        dz_q    <= (bus.Operand2 == '0);
        op1_q   <= bus.Operand1;
        dest_q  <= bus.DestReg;
      end else if (state_q == RUN) begin
        count_q <= count_q + CNT_W'(1);
      end
      // Latch the presented result so the outputs hold it after the pulse
      if (state_q == DONE) begin
        wreg_q  <= dest_q;
        wdata_q <= result;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int WIDTH      = 64;
  localparam int REG_ADDR_W = 5;

  logic Clock;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_div_unit_if #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) bus ();

  mul_div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    case (op)
      2'b00:   return p[63:0];
      2'b01:   return p[127:64];
      2'b10:   return (b == 64'd0) ? {64{1'b1}} : a / b;
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  // Waits for Ready at a falling edge, presents the request, returns just after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] d);
    int guard = 0;
    while (!bus.Ready && guard < 200) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", 64'(bus.Ready), 64'd1);
    bus.Start    = 1'b1;
    bus.Op       = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.DestReg  = d;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // k counts edges since the accepting edge; Done must first be seen at k == WIDTH
  task automatic collect(input string tag, input logic [4:0] exp_reg, input logic [63:0] exp_data,
                         input bit scramble, input bit hold);
    int lat = -1;
    for (int k = 0; k <= WIDTH + 16; k++) begin
      if (bus.Done) begin
        lat = k;
        break;
      end
      if (scramble) begin
        bus.Start    = 1'b1;
        bus.Op       = 2'($urandom);
        bus.Operand1 = {$urandom, $urandom};
        bus.Operand2 = {$urandom, $urandom};
        bus.DestReg  = 5'($urandom);
      end else if (!hold) begin
        bus.Start = 1'b0;
      end
      @(negedge Clock);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    chk({tag, "_regwrite"}, 64'(bus.RegWrite), 64'd1);
    chk({tag, "_writereg"}, 64'(bus.WriteReg), 64'(exp_reg));
    chk({tag, "_writedata"}, bus.WriteData, exp_data);
    if (!hold) bus.Start = 1'b0;
    @(negedge Clock);
    chk({tag, "_single_done"}, 64'(bus.Done), 64'd0);
    chk({tag, "_hold_data"}, bus.WriteData, exp_data);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d);
    issue(op, a, b, d);
    collect(tag, d, ref_result(op, a, b), 1'b0, 1'b0);
  endtask

  initial begin
    int dones;
    logic [63:0] a, b, a2, b2;
    logic [1:0]  op;
    logic [4:0]  d;

    bus.Start    = 1'b0;
    bus.Op       = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    bus.DestReg  = '0;
    Reset_n      = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;

    chk("rst_ready", 64'(bus.Ready), 64'd1);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_writereg", 64'(bus.WriteReg), 64'd0);
    chk("rst_writedata", bus.WriteData, 64'd0);
    dones = 0;
    repeat (100) begin
      @(negedge Clock);
      if (bus.Done || bus.RegWrite) dones++;
    end
    chk("idle_no_done", 64'(dones), 64'd0);

    run_op("mul", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7);
    run_op("mulhu", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7);
    run_op("divu", 2'b10, 64'd100, 64'd7, 5'd3);
    run_op("remu", 2'b11, 64'd100, 64'd7, 5'd4);
    run_op("divu_big", 2'b10, 64'h8000_0000_0000_0000, 64'd3, 5'd31);
    run_op("divu_zero", 2'b10, 64'h1234, 64'd0, 5'd0);
    run_op("remu_zero", 2'b11, 64'h1234, 64'd0, 5'd9);

    // Start held high with scrambled inputs during RUN
    a = {$urandom, $urandom};
    b = 64'($urandom);
    issue(2'b01, a, b, 5'd12);
    collect("scramble", 5'd12, ref_result(2'b01, a, b), 1'b1, 1'b0);

    // Second request held on the inputs through the first operation, taken once Ready rises
    a  = {$urandom, $urandom};
    b  = 64'($urandom_range(1, 1000));
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    issue(2'b11, a, b, 5'd21);
    bus.Start    = 1'b1;
    bus.Op       = 2'b00;
    bus.Operand1 = a2;
    bus.Operand2 = b2;
    bus.DestReg  = 5'd22;
    collect("b2b_first", 5'd21, ref_result(2'b11, a, b), 1'b0, 1'b1);
    chk("b2b_ready", 64'(bus.Ready), 64'd1);
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    collect("b2b_second", 5'd22, ref_result(2'b00, a2, b2), 1'b0, 1'b0);

    // Reset at iteration 30 aborts the operation silently
    issue(2'b00, {$urandom, $urandom}, {$urandom, $urandom}, 5'd5);
    bus.Start = 1'b0;
    repeat (30) @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    chk("midrst_ready", 64'(bus.Ready), 64'd1);
    dones = 0;
    repeat (80) begin
      if (bus.Done || bus.RegWrite) dones++;
      @(negedge Clock);
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    run_op("after_rst_mul", 2'b00, 64'd3, 64'd5, 5'd1);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 255));
        2:       b = 64'($urandom);
        default: b = {$urandom, $urandom};
      endcase
      d = 5'($urandom);
      run_op("rand", op, a, b, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
